// File: rtl/vga_capture_decoder.sv
// Receive side of a VGA link: measures sync/blank timing, locks onto a stable mode
// and emits every visible pixel with its recovered column, row and 5:5:5 colour.
module vga_capture_decoder #(
   parameter bit          SYNC_ACTIVE = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        hs,
   input  logic        vs,
   input  logic        blank_n,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        pixel_valid,
   output logic [11:0] pixel_col,
   output logic [10:0] pixel_row,
   output logic [14:0] pixel_rgb,
   output logic        frame_start,
   output logic        locked,
   output logic        timing_err,
   output logic [11:0] h_total,
   output logic [11:0] h_active,
   output logic [10:0] v_total,
   output logic [10:0] v_active
);

   typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

   localparam logic       SYNC_IDLE  = ~SYNC_ACTIVE;
   localparam logic [3:0] MATCH_LAST = 4'(LOCK_FRAMES - 1);

   logic        hs_q, vs_q, hs_p_q, vs_p_q, de_q;
   logic [14:0] rgb_q;

   logic [11:0] hcnt_q, hcnt_d, hact_q, hact_d;
   logic [10:0] vcnt_q, vcnt_d, vact_q, vact_d;
   logic        line_act_q, line_act_d;
   logic        first_q, first_d, ref_a_v_q, ref_a_v_d;
   logic [11:0] ref_h_q, ref_h_d, ref_a_q, ref_a_d;
   logic        incons_q, incons_d, sat_q, sat_d;

   state_t      state_q, state_d;
   logic [3:0]  match_q, match_d;
   logic [11:0] h_total_q, h_total_d, h_active_q, h_active_d;
   logic [10:0] v_total_q, v_total_d, v_active_q, v_active_d;

   logic        ps_valid_q, ps_valid_d;
   logic [11:0] ps_col_q, ps_col_d;
   logic [10:0] ps_row_q, ps_row_d;
   logic [14:0] ps_rgb_q;

   logic        pixel_valid_q, pixel_valid_d;
   logic [11:0] pixel_col_q, pixel_col_d;
   logic [10:0] pixel_row_q, pixel_row_d;
   logic [14:0] pixel_rgb_q, pixel_rgb_d;
   logic        frame_start_q, locked_q, locked_d, timing_err_q, timing_err_d;

   logic        hs_edge, vs_edge, sat_now, h_bad, a_bad, frame_bad, frame_eq, lock_err, load;
   logic [11:0] line_h, line_a, frame_h, frame_a, col_now;
   logic [10:0] frame_v, frame_va;

   logic unused_lsbs;
   assign unused_lsbs = ^{r[2:0], g[2:0], b[2:0]};

   assign hs_edge = (hs_q == SYNC_ACTIVE) && (hs_p_q == SYNC_IDLE);
   assign vs_edge = (vs_q == SYNC_ACTIVE) && (vs_p_q == SYNC_IDLE);

   // Blanking lines carry no active video, so h_active is only compared across lines that have some.
   always_comb begin
      sat_now   = (&hcnt_q) | (&hact_q) | (&vcnt_q) | (&vact_q);
      line_h    = (&hcnt_q) ? hcnt_q : hcnt_q + 12'd1;
      line_a    = hact_q;
      h_bad     = hs_edge && !first_q && (line_h != ref_h_q);
      a_bad     = hs_edge && line_act_q && ref_a_v_q && (line_a != ref_a_q);
      frame_h   = (hs_edge && first_q) ? line_h : ref_h_q;
      frame_a   = (hs_edge && line_act_q && !ref_a_v_q) ? line_a : ref_a_q;
      frame_v   = vcnt_q;
      if (hs_edge && !(&vcnt_q)) frame_v = vcnt_q + 11'd1;
      frame_va  = vact_q;
      if (hs_edge && line_act_q && !(&vact_q)) frame_va = vact_q + 11'd1;
      frame_bad = incons_q | h_bad | a_bad | sat_q | sat_now;
      frame_eq  = (frame_h == h_total_q) && (frame_a == h_active_q) &&
                  (frame_v == v_total_q) && (frame_va == v_active_q);
      lock_err  = (state_q == LOCKED) &&
                  (sat_now ||
                   (hs_edge && ((line_h != h_total_q) || (line_act_q && (line_a != h_active_q)))) ||
                   (vs_edge && ((frame_v != v_total_q) || (frame_va != v_active_q))));
   end

   always_comb begin
      hcnt_d     = hs_edge ? '0 : ((&hcnt_q) ? hcnt_q : hcnt_q + 12'd1);
      hact_d     = hs_edge ? {11'd0, de_q} : ((de_q && !(&hact_q)) ? hact_q + 12'd1 : hact_q);
      line_act_d = hs_edge ? de_q : (line_act_q | de_q);
      vcnt_d     = vs_edge ? '0 : frame_v;
      vact_d     = vs_edge ? '0 : frame_va;
      first_d    = first_q;
      ref_h_d    = ref_h_q;
      ref_a_d    = ref_a_q;
      ref_a_v_d  = ref_a_v_q;
      incons_d   = incons_q | h_bad | a_bad;
      sat_d      = sat_q | sat_now;
      if (hs_edge && first_q) begin
         ref_h_d = line_h;
         first_d = 1'b0;
      end
      if (hs_edge && line_act_q && !ref_a_v_q) begin
         ref_a_d   = line_a;
         ref_a_v_d = 1'b1;
      end
      // The hs edge above closes the ending frame's last line before the frame state restarts.
      if (vs_edge) begin
         first_d   = 1'b1;
         ref_a_v_d = 1'b0;
         incons_d  = 1'b0;
         sat_d     = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      match_d      = match_q;
      load         = 1'b0;
      timing_err_d = 1'b0;
      case (state_q)
         SEARCH:  if (vs_edge) state_d = MEASURE;
         MEASURE: if (vs_edge && !frame_bad) begin
                     load    = 1'b1;
                     match_d = '0;
                     state_d = VERIFY;
                  end
         VERIFY:  if (vs_edge) begin
                     if (frame_bad) begin
                        state_d = MEASURE;
                     end else if (frame_eq) begin
                        if (match_q == MATCH_LAST) state_d = LOCKED;
                        else                       match_d = match_q + 4'd1;
                     end else begin
                        load    = 1'b1;
                        match_d = '0;
                     end
                  end
         LOCKED:  if (lock_err) begin
                     timing_err_d = 1'b1;
                     state_d      = SEARCH;
                  end
         default: state_d = SEARCH;
      endcase
      h_total_d  = load ? frame_h  : h_total_q;
      h_active_d = load ? frame_a  : h_active_q;
      v_total_d  = load ? frame_v  : v_total_q;
      v_active_d = load ? frame_va : v_active_q;
      locked_d   = (state_d == LOCKED);
   end

   always_comb begin
      col_now       = hs_edge ? '0 : hact_q;
      ps_col_d      = col_now;
      ps_row_d      = vs_edge ? '0 : frame_va;
      ps_valid_d    = (state_q == LOCKED) && !lock_err && de_q &&
                      (col_now < h_active_q) && (ps_row_d < v_active_q);
      pixel_valid_d = ps_valid_q && (state_q == LOCKED) && !lock_err;
      pixel_col_d   = ps_valid_q ? ps_col_q : pixel_col_q;
      pixel_row_d   = ps_valid_q ? ps_row_q : pixel_row_q;
      pixel_rgb_d   = ps_valid_q ? ps_rgb_q : pixel_rgb_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hs_q <= SYNC_IDLE;   vs_q <= SYNC_IDLE;
         hs_p_q <= SYNC_IDLE; vs_p_q <= SYNC_IDLE;
         de_q <= 1'b0;        rgb_q <= '0;
         hcnt_q <= '0; hact_q <= '0; vcnt_q <= '0; vact_q <= '0;
         line_act_q <= 1'b0; first_q <= 1'b1; ref_a_v_q <= 1'b0;
         ref_h_q <= '0; ref_a_q <= '0; incons_q <= 1'b0; sat_q <= 1'b0;
         state_q <= SEARCH; match_q <= '0;
         h_total_q <= '0; h_active_q <= '0; v_total_q <= '0; v_active_q <= '0;
         ps_valid_q <= 1'b0; ps_col_q <= '0; ps_row_q <= '0; ps_rgb_q <= '0;
         pixel_valid_q <= 1'b0; pixel_col_q <= '0; pixel_row_q <= '0; pixel_rgb_q <= '0;
         frame_start_q <= 1'b0; locked_q <= 1'b0; timing_err_q <= 1'b0;
      end else begin
         hs_q <= hs;          vs_q <= vs;
         hs_p_q <= hs_q;      vs_p_q <= vs_q;
         de_q <= blank_n;     rgb_q <= {r[7:3], g[7:3], b[7:3]};
         hcnt_q <= hcnt_d; hact_q <= hact_d; vcnt_q <= vcnt_d; vact_q <= vact_d;
         line_act_q <= line_act_d; first_q <= first_d; ref_a_v_q <= ref_a_v_d;
         ref_h_q <= ref_h_d; ref_a_q <= ref_a_d; incons_q <= incons_d; sat_q <= sat_d;
         state_q <= state_d; match_q <= match_d;
         h_total_q <= h_total_d; h_active_q <= h_active_d;
         v_total_q <= v_total_d; v_active_q <= v_active_d;
         ps_valid_q <= ps_valid_d; ps_col_q <= ps_col_d; ps_row_q <= ps_row_d; ps_rgb_q <= rgb_q;
         pixel_valid_q <= pixel_valid_d; pixel_col_q <= pixel_col_d;
         pixel_row_q <= pixel_row_d; pixel_rgb_q <= pixel_rgb_d;
         frame_start_q <= vs_edge; locked_q <= locked_d; timing_err_q <= timing_err_d;
      end
   end

   assign pixel_valid = pixel_valid_q;
   assign pixel_col   = pixel_col_q;
   assign pixel_row   = pixel_row_q;
   assign pixel_rgb   = pixel_rgb_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign timing_err  = timing_err_q;
   assign h_total     = h_total_q;
   assign h_active    = h_active_q;
   assign v_total     = v_total_q;
   assign v_active    = v_active_q;

endmodule
